// File: rtl/warp_scheduler_pkg.sv
// Shared types for the multi-warp core scheduler: pipeline and per-warp states
// plus the warp eligibility rule used by the selector.
package warp_scheduler_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        REQUEST = 4'd3,
        WAIT    = 4'd4,
        EXECUTE = 4'd5,
        UPDATE  = 4'd6,
        SELECT  = 4'd7,
        DONE    = 4'd8
    } corestate_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_READY   = 2'd1,
        W_MEMWAIT = 2'd2,
        W_DONE    = 2'd3
    } warpstate_t;

    // A parked warp becomes runnable again once its LSUs have drained.
    function automatic logic warp_eligible(input warpstate_t st, input logic busy);
        return (st == W_READY) || ((st == W_MEMWAIT) && !busy);
    endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or after base,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] base,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx
);

    logic [N-1:0]        rot_s;
    logic [IDX_BITS-1:0] off_s;
    logic [IDX_BITS:0]   sum_s;
    logic [IDX_BITS:0]   wrap_s;

    // Rotate requests so base sits at bit 0, take the lowest offset, rotate back.
    always_comb begin
        rot_s       = N'({req, req} >> base);
        grant_valid = |rot_s;
        off_s       = {IDX_BITS{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IDX_BITS'(i) : off_s;
        end
        sum_s     = {1'b0, base} + {1'b0, off_s};
        wrap_s    = sum_s - (IDX_BITS + 1)'(N);
        grant_idx = (sum_s >= (IDX_BITS + 1)'(N)) ? wrap_s[IDX_BITS-1:0]
                                                  : sum_s[IDX_BITS-1:0];
    end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp core scheduler: one shared FETCH..UPDATE control pipeline
// time-multiplexed over NUM_WARPS contexts, switching warps only on stall or RET.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int PC_BITS   = 8,
    parameter int WARP_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_WARPS-1:0] warp_enable,
    input  logic                 fetcher_done,
    input  logic                 decoded_ret,
    input  logic                 decoded_mem_access,
    input  logic [NUM_WARPS-1:0] lsu_busy,
    input  logic [PC_BITS-1:0]   next_pc,
    output logic [3:0]           core_state,
    output logic [WARP_BITS-1:0] active_warp,
    output logic [PC_BITS-1:0]   current_pc,
    output logic                 replay,
    output logic [NUM_WARPS-1:0] warp_done,
    output logic                 done
);

    corestate_t             state_r,     state_nx_s;
    logic [WARP_BITS-1:0]   active_r,    active_nx_s;
    logic [PC_BITS-1:0]     cur_pc_r,    cur_pc_nx_s;
    logic                   replay_r,    replay_nx_s;
    logic [NUM_WARPS-1:0]   warp_done_r, warp_done_nx_s;
    logic                   done_r,      done_nx_s;
    logic [PC_BITS-1:0]     pc_r        [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_nx_s     [NUM_WARPS];
    warpstate_t             status_r    [NUM_WARPS];
    warpstate_t             status_nx_s [NUM_WARPS];
    logic [NUM_WARPS-1:0]   rflag_r,     rflag_nx_s;

    logic [NUM_WARPS-1:0]   elig_s;
    logic                   live_s;
    logic [WARP_BITS-1:0]   base_s;
    logic                   sel_valid_s;
    logic [WARP_BITS-1:0]   sel_idx_s;
    logic                   first_valid_s;
    logic [WARP_BITS-1:0]   first_idx_s;

    // Eligibility vector, "any warp still running" flag and round-robin start point.
    always_comb begin
        elig_s = {NUM_WARPS{1'b0}};
        live_s = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            elig_s[w] = warp_eligible(status_r[w], lsu_busy[w]);
            live_s    = live_s | (status_r[w] == W_READY) | (status_r[w] == W_MEMWAIT);
        end
        // Searching from active+1 leaves the current warp as the last candidate.
        base_s = (active_r == WARP_BITS'(NUM_WARPS - 1)) ? {WARP_BITS{1'b0}}
                                                         : active_r + WARP_BITS'(1);
    end

    rr_arbiter #(.N(NUM_WARPS), .IDX_BITS(WARP_BITS)) u_select (
        .req         (elig_s),
        .base        (base_s),
        .grant_valid (sel_valid_s),
        .grant_idx   (sel_idx_s)
    );

    rr_arbiter #(.N(NUM_WARPS), .IDX_BITS(WARP_BITS)) u_first (
        .req         (warp_enable),
        .base        ({WARP_BITS{1'b0}}),
        .grant_valid (first_valid_s),
        .grant_idx   (first_idx_s)
    );

    // Next-state and next-context logic for the shared pipeline.
    always_comb begin
        state_nx_s     = state_r;
        active_nx_s    = active_r;
        cur_pc_nx_s    = cur_pc_r;
        replay_nx_s    = replay_r;
        warp_done_nx_s = warp_done_r;
        done_nx_s      = done_r;
        pc_nx_s        = pc_r;
        status_nx_s    = status_r;
        rflag_nx_s     = rflag_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    warp_done_nx_s = {NUM_WARPS{1'b0}};
                    rflag_nx_s     = {NUM_WARPS{1'b0}};
                    cur_pc_nx_s    = {PC_BITS{1'b0}};
                    replay_nx_s    = 1'b0;
                    for (int w = 0; w < NUM_WARPS; w++) begin
                        pc_nx_s[w]     = {PC_BITS{1'b0}};
                        status_nx_s[w] = warp_enable[w] ? W_READY : W_IDLE;
                    end
                    if (first_valid_s) begin
                        active_nx_s = first_idx_s;
                        done_nx_s   = 1'b0;
                        state_nx_s  = FETCH;
                    end else begin
                        done_nx_s   = 1'b1;
                        state_nx_s  = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
                state_nx_s = fetcher_done ? DECODE : FETCH;
            end
            DECODE: begin
                // A resumed memory op already has its data; skip the request.
                state_nx_s = replay_r ? EXECUTE : REQUEST;
            end
            REQUEST: begin
                if (decoded_ret) begin
                    warp_done_nx_s[active_r] = 1'b1;
                    status_nx_s[active_r]    = W_DONE;
                    state_nx_s               = SELECT;
                end else if (decoded_mem_access) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = EXECUTE;
                end
            end
            WAIT: begin
                if (!lsu_busy[active_r]) begin
                    state_nx_s = EXECUTE;
                end else begin
                    status_nx_s[active_r] = W_MEMWAIT;
                    rflag_nx_s[active_r]  = 1'b1;
                    state_nx_s            = SELECT;
                end
            end
            EXECUTE: begin
                state_nx_s = UPDATE;
            end
            UPDATE: begin
                pc_nx_s[active_r]     = next_pc;
                cur_pc_nx_s           = next_pc;
                rflag_nx_s[active_r]  = 1'b0;
                replay_nx_s           = 1'b0;
                status_nx_s[active_r] = W_READY;
                state_nx_s            = FETCH;
            end
            SELECT: begin
                if (sel_valid_s) begin
                    active_nx_s            = sel_idx_s;
                    cur_pc_nx_s            = pc_r[sel_idx_s];
                    replay_nx_s            = rflag_r[sel_idx_s];
                    status_nx_s[sel_idx_s] = W_READY;
                    state_nx_s             = FETCH;
                end else if (!live_s) begin
                    done_nx_s  = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SELECT;
                end
            end
            DONE: begin
                done_nx_s  = 1'b1;
                state_nx_s = start ? DONE : IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Pipeline and per-warp context registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            active_r    <= {WARP_BITS{1'b0}};
            cur_pc_r    <= {PC_BITS{1'b0}};
            replay_r    <= 1'b0;
            warp_done_r <= {NUM_WARPS{1'b0}};
            done_r      <= 1'b0;
            rflag_r     <= {NUM_WARPS{1'b0}};
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_r[w]     <= {PC_BITS{1'b0}};
                status_r[w] <= W_IDLE;
            end
        end else begin
            state_r     <= state_nx_s;
            active_r    <= active_nx_s;
            cur_pc_r    <= cur_pc_nx_s;
            replay_r    <= replay_nx_s;
            warp_done_r <= warp_done_nx_s;
            done_r      <= done_nx_s;
            rflag_r     <= rflag_nx_s;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_r[w]     <= pc_nx_s[w];
                status_r[w] <= status_nx_s[w];
            end
        end
    end

    assign core_state  = state_r;
    assign active_warp = active_r;
    assign current_pc  = cur_pc_r;
    assign replay      = replay_r;
    assign warp_done   = warp_done_r;
    assign done        = done_r;

endmodule
